// File: rtl/kyber512_pkg.sv
// Shared Kyber512 constants, poly-id encodings and state/stage types
// for the ciphertext decompression front end.
package kyber512_pkg;
  localparam int KYBER_Q  = 3329;
  localparam int KYBER_N  = 256;
  localparam int KYBER_K  = 2;
  localparam int KYBER_DU = 10;
  localparam int KYBER_DV = 3;
  localparam int CT_W     = 5888;
  localparam int U_W      = 5120;

  typedef enum logic [1:0] {
    POLY_U0 = 2'd0,
    POLY_U1 = 2'd1,
    POLY_V  = 2'd2
  } poly_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Stage-1 payload: raw compressed field plus its running beat number.
  typedef struct packed {
    logic [9:0] field;
    logic [9:0] cnt;
  } s1_t;
endpackage

// File: rtl/kyber512_ct_decompress_if.sv
// Coefficient stream (valid/ready) leaving the decompressor.
interface kyber512_ct_decompress_if;
  logic        o_valid;
  logic        i_ready;
  logic [11:0] o_coeff;
  logic [1:0]  o_poly;
  logic [7:0]  o_index;
  logic        o_last;

  modport master (
    output o_valid, o_coeff, o_poly, o_index, o_last,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_coeff, o_poly, o_index, o_last,
    output i_ready
  );
endinterface

// File: rtl/kyber_decompress_coeff.sv
// Combinational Kyber decompression: (x*Q + 2^(d-1)) >> d, result < Q.
module kyber_decompress_coeff
  import kyber512_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [9:0]  i_x,
  input  logic [3:0]  i_d,
  output logic [11:0] o_c
);
  logic [21:0] w_prod;
  logic [21:0] w_rnd;
  logic [21:0] w_sum;

  always_comb begin
    w_prod = 22'(i_x) * 22'(Q);
    w_rnd  = 22'(1) << (i_d - 4'd1);
    w_sum  = w_prod + w_rnd;
    o_c    = 12'(w_sum >> i_d);
  end
endmodule

// File: rtl/kyber512_ct_decompress.sv
// Unpacks a Kyber512 ciphertext (2 x u at du=10, v at dv=3) and streams
// every decompressed coefficient out through a two-stage valid/ready pipe.
module kyber512_ct_decompress
  import kyber512_pkg::*;
#(
  parameter int Q  = KYBER_Q,
  parameter int N  = KYBER_N,
  parameter int K  = KYBER_K,
  parameter int DU = KYBER_DU,
  parameter int DV = KYBER_DV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CT_W-1:0]         i_Ciphertext,
  output logic                    busy,
  output logic                    done,
  kyber512_ct_decompress_if.master o_strm
);
  localparam logic [9:0] U_CNT  = 10'(U_W / DU);
  localparam logic [9:0] LAST_C = 10'((K + 1) * N - 1);

  state_e          r_state, w_state_nxt;
  logic [CT_W-1:0] r_sr;
  logic [9:0]      r_cnt;
  s1_t             r_s1;
  logic [1:0]      r_vld_pipe;
  logic [11:0]     r_coeff;
  logic [1:0]      r_poly;
  logic [7:0]      r_index;
  logic            r_last;
  logic            r_done;

  logic            w_adv;
  logic            w_issue;
  logic            w_in_u;
  logic [9:0]      w_field;
  logic [3:0]      w_d;
  logic [11:0]     w_coeff;
  logic            w_fin;

  assign w_adv   = !r_vld_pipe[1] || o_strm.i_ready;
  assign w_issue = (r_state == ST_RUN) && w_adv;
  assign w_in_u  = r_cnt < U_CNT;
  assign w_field = w_in_u ? r_sr[9:0] : {7'd0, r_sr[2:0]};
  assign w_d     = (r_s1.cnt[9:8] == POLY_V) ? 4'(DV) : 4'(DU);

  kyber_decompress_coeff #(.Q(Q)) u_coeff (
    .i_x (r_s1.field),
    .i_d (w_d),
    .o_c (w_coeff)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue && r_cnt == LAST_C) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_vld_pipe[1] && o_strm.i_ready && r_last) begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_s1       <= '0;
      r_vld_pipe <= '0;
      r_coeff    <= '0;
      r_poly     <= '0;
      r_index    <= '0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_fin;
      // Beat 0 is staged straight from the input so the first output
      // lands two cycles after start; the counter then resumes at 1.
      if (r_state == ST_IDLE && start) begin
        r_sr          <= i_Ciphertext >> DU;
        r_cnt         <= 10'd1;
        r_s1          <= '{field: i_Ciphertext[9:0], cnt: 10'd0};
        r_vld_pipe[0] <= 1'b1;
      end else if (w_adv) begin
        r_vld_pipe[0] <= w_issue;
        if (w_issue) begin
          r_s1  <= '{field: w_field, cnt: r_cnt};
          r_cnt <= r_cnt + 10'd1;
          r_sr  <= w_in_u ? (r_sr >> DU) : (r_sr >> DV);
        end
      end
      if (w_adv) begin
        r_vld_pipe[1] <= r_vld_pipe[0];
        if (r_vld_pipe[0]) begin
          r_coeff <= w_coeff;
          r_poly  <= r_s1.cnt[9:8];
          r_index <= r_s1.cnt[7:0];
          r_last  <= (r_s1.cnt == LAST_C);
        end
      end
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign o_strm.o_valid = r_vld_pipe[1];
  assign o_strm.o_coeff = r_coeff;
  assign o_strm.o_poly  = r_poly;
  assign o_strm.o_index = r_index;
  assign o_strm.o_last  = r_last;
endmodule

// File: tb/tb_kyber512_ct_decompress.sv
// Scoreboard bench for kyber512_ct_decompress: expected beats are queued at
// start and popped by a negedge monitor on every handshake.
module tb_kyber512_ct_decompress;
  import kyber512_pkg::*;

  typedef struct packed {
    logic [11:0] c;
    logic [1:0]  p;
    logic [7:0]  i;
    logic        l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CT_W-1:0] ct_in = '0;
  logic            busy, done;
  int              cyc = 0;
  int              n_tests = 0;
  int              n_fail = 0;
  beat_t           sb[$];

  kyber512_ct_decompress_if s_if();

  kyber512_ct_decompress dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .i_Ciphertext (ct_in),
    .busy         (busy),
    .done         (done),
    .o_strm       (s_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-half-up of x*Q/2^d, written as a division.
  function automatic int model(input int x, input int d);
    return (2 * x * 3329 + (1 << d)) / (1 << (d + 1));
  endfunction

  function automatic logic [CT_W-1:0] rand_ct();
    logic [CT_W-1:0] c;
    for (int w = 0; w < CT_W / 32; w++) c[w*32 +: 32] = $urandom();
    return c;
  endfunction

  task automatic push_exp(input logic [CT_W-1:0] c);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 256; i++) begin
        int x;
        beat_t b;
        if (p < 2) x = int'(c[(p*256+i)*10 +: 10]);
        else       x = int'(c[5120+i*3 +: 3]);
        b.c = 12'(model(x, (p < 2) ? 10 : 3));
        b.p = 2'(p);
        b.i = 8'(i);
        b.l = (p == 2 && i == 255);
        sb.push_back(b);
      end
  endtask

  // Called mid-cycle; start is sampled at the next rising edge (cycle T).
  task automatic do_start(input logic [CT_W-1:0] c, output int t);
    ct_in = c;
    start = 1'b1;
    push_exp(c);
    t = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_stream(input int pct, input int pulse_at, input bit stop_at_done,
                            output int t_first, output int t_last, output int t_done,
                            output int n_done, output logic busy_dn);
    t_first = -1; t_last = -1; t_done = -1; n_done = 0; busy_dn = 1'bx;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      s_if.i_ready = ($urandom_range(99) < pct);
      start = (c == pulse_at);
      if (c == pulse_at) ct_in = rand_ct();
      @(negedge clk);
      if (s_if.o_valid && t_first < 0) t_first = cyc;
      if (s_if.o_valid && s_if.o_last && t_last < 0) t_last = cyc;
      if (done) begin
        n_done++;
        if (t_done < 0) begin t_done = cyc; busy_dn = busy; end
      end
      if (t_done >= 0 && (stop_at_done || cyc >= t_done + 3)) break;
    end
  endtask

  task automatic monitor();
    beat_t got, prev, exp;
    bit stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = '{c: s_if.o_coeff, p: s_if.o_poly, i: s_if.o_index, l: s_if.o_last};
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          n_tests++;
          if (!s_if.o_valid || got !== prev) begin
            n_fail++;
            $display("FAIL stall_hold got v=%0d %h exp v=1 %h", s_if.o_valid, got, prev);
          end
        end
        if (s_if.o_valid && s_if.i_ready) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL extra_beat got c=%0d p=%0d i=%0d exp none", got.c, got.p, got.i);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL beat got c=%0d p=%0d i=%0d l=%0d exp c=%0d p=%0d i=%0d l=%0d",
                       got.c, got.p, got.i, got.l, exp.c, exp.p, exp.i, exp.l);
            end
          end
        end
        stalled = s_if.o_valid && !s_if.i_ready;
        prev = got;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, s_if.o_valid, s_if.o_last} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 0000", {busy, done, s_if.o_valid, s_if.o_last});
    end
    n_tests++;
    if (s_if.o_coeff !== 12'd0) begin
      n_fail++; $display("FAIL reset_coeff got %0d exp 0", s_if.o_coeff);
    end
    n_tests++;
    if ({s_if.o_poly, s_if.o_index} !== 10'd0) begin
      n_fail++; $display("FAIL reset_tag got %0d/%0d exp 0/0", s_if.o_poly, s_if.o_index);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_zero();
    int t, tf, tl, td, nd;
    logic bd;
    do_start('0, t);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || s_if.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_t1 got busy=%0d valid=%0d exp 1/0", busy, s_if.o_valid);
    end
    run_stream(100, -1, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (tf !== t + 2) begin n_fail++; $display("FAIL first_valid got %0d exp %0d", tf - t, 2); end
    n_tests++;
    if (tl !== t + 769) begin n_fail++; $display("FAIL last_time got %0d exp %0d", tl - t, 769); end
    n_tests++;
    if (td !== t + 770 || nd !== 1) begin
      n_fail++; $display("FAIL done_time got %0d (x%0d) exp 770 (x1)", td - t, nd);
    end
    n_tests++;
    if (bd !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %0d exp 0", bd); end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL zero_left got %0d exp 0", sb.size()); end
  endtask

  task automatic test_directed();
    logic [CT_W-1:0] c;
    int t, tf, tl, td, nd;
    logic bd;
    c = '0;
    c[0 +: 10] = 10'd1;
    c[(256+255)*10 +: 10] = 10'd1023;
    c[5120 +: 3] = 3'd1;
    c[5120+255*3 +: 3] = 3'd7;
    do_start(c, t);
    run_stream(100, -1, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (nd !== 1 || sb.size() != 0) begin
      n_fail++; $display("FAIL directed_end got done=%0d left=%0d exp 1/0", nd, sb.size());
    end
  endtask

  task automatic test_v4();
    logic [CT_W-1:0] c;
    int t, tf, tl, td, nd;
    logic bd;
    c = '0;
    for (int i = 0; i < 256; i++) c[5120+i*3 +: 3] = 3'd4;
    c[5*10 +: 10] = 10'd512;
    do_start(c, t);
    run_stream(100, -1, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (nd !== 1 || sb.size() != 0) begin
      n_fail++; $display("FAIL v4_end got done=%0d left=%0d exp 1/0", nd, sb.size());
    end
  endtask

  task automatic test_random();
    int t, tf, tl, td, nd;
    logic bd;
    for (int r = 0; r < 2; r++) begin
      do_start(rand_ct(), t);
      run_stream(50, -1, 0, tf, tl, td, nd, bd);
      n_tests++;
      if (nd !== 1 || sb.size() != 0 || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL random_end got done=%0d left=%0d busy=%0d exp 1/0/0", nd, sb.size(), bd);
      end
    end
  endtask

  task automatic test_start_midstream();
    int t, tf, tl, td, nd;
    logic bd;
    do_start(rand_ct(), t);
    run_stream(70, 100, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (nd !== 1 || sb.size() != 0) begin
      n_fail++; $display("FAIL mid_start got done=%0d left=%0d exp 1/0", nd, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    int t, tf, tl, td, nd, bad;
    logic bd;
    s_if.i_ready = 1'b1;
    do_start(rand_ct(), t);
    for (int g = 0; g < 400 && cyc < t + 302; g++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, s_if.o_valid, s_if.o_last, s_if.o_poly, s_if.o_index, s_if.o_coeff} !== 26'd0) begin
      n_fail++;
      $display("FAIL rst_mid got busy=%0d v=%0d c=%0d p=%0d i=%0d exp all 0",
               busy, s_if.o_valid, s_if.o_coeff, s_if.o_poly, s_if.o_index);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || s_if.o_valid) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_quiet got %0d active cycles exp 0", bad); end
    do_start(rand_ct(), t);
    run_stream(100, -1, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (tf !== t + 2 || nd !== 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_restart got first=%0d done=%0d left=%0d exp 2/1/0", tf - t, nd, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, tf, tl, td, nd;
    logic bd;
    s_if.i_ready = 1'b1;
    do_start(rand_ct(), t1);
    run_stream(100, -1, 1, tf, tl, td, nd, bd);
    n_tests++;
    if (td !== t1 + 770) begin n_fail++; $display("FAIL b2b_done got %0d exp 770", td - t1); end
    do_start(rand_ct(), t2);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %0d exp 1", busy); end
    run_stream(100, -1, 0, tf, tl, td, nd, bd);
    n_tests++;
    if (tf !== t2 + 2 || nd !== 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_stream got first=%0d done=%0d left=%0d exp 2/1/0", tf - t2, nd, sb.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    s_if.i_ready = 1'b1;
    test_reset();
    test_zero();
    test_directed();
    test_v4();
    test_random();
    test_start_midstream();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kyber512_ct_decompress.md
# kyber512_ct_decompress

Receive-side counterpart of the Kyber512 encapsulation datapath. Takes the 5888-bit packed ciphertext produced by encapsulation (two u polynomials at du=10, one v polynomial at dv=3) and unpacks it. Decompresses every coefficient to Z_q and streams them out one per cycle over a valid/ready handshake. Sits at the front of the decapsulation (IND-CPA decrypt) path, feeding the NTT of u and the subtraction with v.

## Interface
Parameters:
- `Q`, 3329, Kyber modulus
- `N`, 256, coefficients per polynomial
- `K`, 2, number of u polynomials
- `DU`, 10, u compression bits
- `DV`, 3, v compression bits

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `i_Ciphertext`  in  5888  packed ciphertext, sampled on the accepted `start` cycle
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `o_valid`  out  1  output coefficient valid
- `i_ready`  in  1  downstream accepts when `o_valid && i_ready`
- `o_coeff`  out  12  decompressed coefficient, 0..Q-1
- `o_poly`  out  2  0,1 = u[0],u[1]; 2 = v
- `o_index`  out  8  coefficient index 0..255
- `o_last`  out  1  high with the final coefficient (poly 2, index 255)
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- Packing, fixed:
  - u[k][i] = `i_Ciphertext[(k*256+i)*10 +: 10]`
  - v[i] = `i_Ciphertext[5120 + i*3 +: 3]`
- Decompress: c = (x*Q + 2^(d-1)) >> d, with d = DU for u and d = DV for v.
  - Product width 22 bits; result fits in 12 bits.
  - No mod reduction is needed; the result is always < Q.
- FSM:
  - IDLE: on `start`, latch ciphertext into a 5888-bit shift register, clear counters, go to RUN.
  - RUN: issue one field per advance. Shift by 10 while in u, by 3 while in v. Counter 0..767 gives poly = cnt[9:8], index = cnt[7:0]. After issuing count 767, go to FLUSH.
  - FLUSH: wait for the handshake on the `o_last` beat, then assert `done`, go to IDLE.
- Pipeline: stage 1 is the extracted field plus tag; stage 2 is the multiply/round output register.
  - The pipeline advances when `!o_valid || i_ready`; otherwise everything holds.
  - `o_coeff`, `o_poly`, `o_index` and `o_last` are stable while `o_valid && !i_ready`.
- `start` while busy is ignored; the latched ciphertext is unaffected.
- Reset (at any time, including mid-stream): state IDLE, counters 0, all outputs 0. Any partial stream is abandoned and no `done` is produced.

## Timing
- Reset values: `busy`=0, `o_valid`=0, `o_coeff`=0, `o_poly`=0, `o_index`=0, `o_last`=0, `done`=0.
- Accepted `start` at cycle T:
  - `busy`=1 at T+1.
  - First `o_valid` (poly 0, index 0) at T+2.
- With `i_ready` held high:
  - One coefficient per cycle.
  - `o_last` at T+769.
  - `done`=1 and `busy`=0 at T+770.
  - `start` is accepted again from T+770.
- Each low cycle of `i_ready` while `o_valid`=1 adds exactly one cycle; no beat is dropped or duplicated.
- `done` may coincide with a new `start` only if that `start` is presented in IDLE, i.e. from T+770 onward.

## Structure
- Shared `kyber512_pkg`: Q, N, K, DU, DV, ciphertext width 5888, the u region width 5120, and the poly-id encodings.
- One sub-module, `kyber_decompress_coeff`: combinational (x*Q + round) >> d with `d` as an input (10 or 3), 12-bit output. It is instantiated once, in front of stage 2.

## Test plan
- All-zero ciphertext, `i_ready`=1 -> 768 beats, all `o_coeff`=0. `o_last` on poly 2 / index 255 at T+769; `done` at T+770.
- u[0][0]=1, u[1][255]=1023, v[0]=1, v[255]=7, rest 0 -> `o_coeff` = 3, 3326, 416, 2913 at those positions; all other beats 0.
- v[i]=4 for all i -> all 256 v beats = 1665. u field 512 -> 1665 (spot check u[0][5]).
- Pseudo-random ciphertext with random `i_Ciphertext` values and `i_ready` toggling ~50% -> output sequence matches a reference model in order. No beat is lost or duplicated, and outputs are stable while stalled.
- `start` pulsed mid-stream with different data -> the stream continues from the original ciphertext and `done` fires exactly once.
- `rst` asserted at beat 300 -> next cycle all outputs are 0 and `busy`=0. A new `start` then produces a full, correct 768-beat stream from index 0.
